axi_lite_to_axi_dw: RTL

AXI4-Lite slave to AXI4 master bridge where the AXI4 data bus may be a power-of-two multiple of the Lite data width. Narrow Lite beats are steered onto the correct byte lanes of the wide bus. Per-transaction lane offsets are tracked so that read data is extracted from the matching lane. Outstanding reads and writes are bounded. The block sits at the edge of a Lite peripheral island, feeding a wide AXI4 crossbar or memory.

---
 rtl/axi_lite_to_axi_dw_pkg.sv | 119 +++++++++++
 rtl/axi_lite_to_axi_dw_fifo.sv | 53 +++++
 rtl/axi_lite_to_axi_dw.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axi_lite_to_axi_dw_pkg.sv
// Shared types for the Lite-to-AXI4 width-converting bridge.
// Channel widths are fixed here. The bridge top takes its struct types
// as type parameters, so a different integration can pass its own types.
package axi_lite_to_axi_dw_pkg;

    localparam int unsigned LITE_DW = 32;
    localparam int unsigned AXI_DW  = 128;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned USER_W  = 1;

    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;
    typedef logic [1:0] xresp_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam xresp_t RESP_OKAY   = 2'b00;
    localparam xresp_t RESP_SLVERR = 2'b10;

    // Lite side
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        prot;
    } lite_ax_t;

    typedef struct packed {
        logic [LITE_DW-1:0]   data;
        logic [LITE_DW/8-1:0] strb;
    } lite_w_t;

    typedef struct packed {
        xresp_t resp;
    } lite_b_t;

    typedef struct packed {
        logic [LITE_DW-1:0] data;
        xresp_t             resp;
    } lite_r_t;

    typedef struct packed {
        lite_ax_t aw;
        logic     aw_valid;
        lite_w_t  w;
        logic     w_valid;
        logic     b_ready;
        lite_ax_t ar;
        logic     ar_valid;
        logic     r_ready;
    } lite_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        lite_b_t b;
        logic    b_valid;
        logic    ar_ready;
        lite_r_t r;
        logic    r_valid;
    } lite_resp_t;

    // AXI4 side
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        size_t             size;
        burst_t            burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } axi_ax_t;

    typedef struct packed {
        logic [AXI_DW-1:0]   data;
        logic [AXI_DW/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } axi_w_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        xresp_t            resp;
        logic [USER_W-1:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [AXI_DW-1:0] data;
        xresp_t            resp;
        logic              last;
        logic [USER_W-1:0] user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;

endpackage

// File: rtl/axi_lite_to_axi_dw_fifo.sv
// Small registered (non fall-through) FIFO that holds per-transaction
// lane offsets. Data pushed in one cycle is visible at the head the next cycle.
module axi_lite_to_axi_dw_fifo #(
    parameter int unsigned DataWidth = 1,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Depth-1:0][DataWidth-1:0] mem_q;
    logic [PtrW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]                 cnt_q;
    logic                            push, pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i & ~full_o;
    assign pop     = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Storage, circular pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
        end
    end

endmodule

// File: rtl/axi_lite_to_axi_dw.sv
// AXI4-Lite slave to AXI4 master bridge. The AXI4 data bus may be a
// power-of-two multiple of the Lite width. Write beats are replicated
// across all lanes and strobed onto the lane selected by the address.
// Read data is taken from the lane recorded when the AR was accepted.
// All IDs are zero, so responses return in order and FIFO heads always match.
module axi_lite_to_axi_dw
    import axi_lite_to_axi_dw_pkg::*;
#(
    parameter int unsigned LiteDataWidth = LITE_DW,
    parameter int unsigned AxiDataWidth  = AXI_DW,
    parameter int unsigned AxiAddrWidth  = ADDR_W,
    parameter int unsigned MaxWrites     = 4,
    parameter int unsigned MaxReads      = 4,
    parameter type req_lite_t  = lite_req_t,
    parameter type resp_lite_t = lite_resp_t,
    parameter type req_t       = axi_req_t,
    parameter type resp_t      = axi_resp_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  req_lite_t  slv_req_lite_i,
    output resp_lite_t slv_resp_lite_o,
    output req_t       mst_req_o,
    input  resp_t      mst_resp_i
);

    localparam int unsigned LiteBytes = LiteDataWidth / 8;
    localparam int unsigned AxiBytes  = AxiDataWidth / 8;
    localparam int unsigned NumLanes  = AxiDataWidth / LiteDataWidth;
    localparam int unsigned OffW      = $clog2(NumLanes);
    localparam int unsigned FifoW     = (OffW > 0) ? OffW : 1;
    localparam int unsigned CntW      = $clog2(MaxWrites + 1);

    logic [FifoW-1:0] aw_off, ar_off, w_off, r_off;
    logic             woff_full, woff_empty, roff_full, roff_empty;
    logic [CntW-1:0]  wcnt_q;
    logic             aw_gate, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic [NumLanes-1:0][LiteDataWidth-1:0] w_lanes, r_lanes;
    logic [NumLanes-1:0][LiteBytes-1:0]     strb_lanes;

    // Lane offset is the address bits between the Lite and AXI byte widths.
    if (OffW > 0) begin : g_off
        assign aw_off = slv_req_lite_i.aw.addr[$clog2(AxiBytes)-1:$clog2(LiteBytes)];
        assign ar_off = slv_req_lite_i.ar.addr[$clog2(AxiBytes)-1:$clog2(LiteBytes)];
    end else begin : g_no_off
        assign aw_off = '0;
        assign ar_off = '0;
    end

    // Gating uses registered state only, so valids never depend on readies.
    assign aw_gate = (wcnt_q < CntW'(MaxWrites)) & ~woff_full;
    assign aw_hs   = slv_req_lite_i.aw_valid & aw_gate & mst_resp_i.aw_ready;
    assign w_hs    = slv_req_lite_i.w_valid & ~woff_empty & mst_resp_i.w_ready;
    assign b_hs    = mst_resp_i.b_valid & slv_req_lite_i.b_ready;
    assign ar_hs   = slv_req_lite_i.ar_valid & ~roff_full & mst_resp_i.ar_ready;
    assign r_hs    = mst_resp_i.r_valid & ~roff_empty & slv_req_lite_i.r_ready;

    // Per-lane steering: data replicated everywhere, strobe only on the target lane.
    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        localparam logic [FifoW-1:0] LaneIdx = FifoW'(l);
        assign w_lanes[l]    = slv_req_lite_i.w.data;
        assign strb_lanes[l] = (w_off == LaneIdx) ? slv_req_lite_i.w.strb : '0;
    end
    assign r_lanes = mst_resp_i.r.data;

    axi_lite_to_axi_dw_fifo #(
        .DataWidth (FifoW),
        .Depth     (MaxWrites)
    ) i_woff_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (aw_hs),
        .data_i  (aw_off),
        .pop_i   (w_hs),
        .data_o  (w_off),
        .full_o  (woff_full),
        .empty_o (woff_empty)
    );

    axi_lite_to_axi_dw_fifo #(
        .DataWidth (FifoW),
        .Depth     (MaxReads)
    ) i_roff_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ar_hs),
        .data_i  (ar_off),
        .pop_i   (r_hs),
        .data_o  (r_off),
        .full_o  (roff_full),
        .empty_o (roff_empty)
    );

    // Outstanding-write counter; AW and B in the same cycle cancel out.
    // A stray B with nothing outstanding is ignored rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
        end else if (aw_hs && !b_hs) begin
            wcnt_q <= wcnt_q + CntW'(1);
        end else if (b_hs && !aw_hs && (wcnt_q != '0)) begin
            wcnt_q <= wcnt_q - CntW'(1);
        end
    end

    // Downstream request: single-beat FIXED bursts at Lite size, all IDs zero.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw.addr  = slv_req_lite_i.aw.addr;
        mst_req_o.aw.prot  = slv_req_lite_i.aw.prot;
        mst_req_o.aw.size  = size_t'($clog2(LiteBytes));
        mst_req_o.aw.burst = BURST_FIXED;
        mst_req_o.aw_valid = slv_req_lite_i.aw_valid & aw_gate;
        mst_req_o.w.data   = w_lanes;
        mst_req_o.w.strb   = strb_lanes;
        mst_req_o.w.last   = 1'b1;
        mst_req_o.w_valid  = slv_req_lite_i.w_valid & ~woff_empty;
        mst_req_o.b_ready  = slv_req_lite_i.b_ready;
        mst_req_o.ar.addr  = slv_req_lite_i.ar.addr;
        mst_req_o.ar.prot  = slv_req_lite_i.ar.prot;
        mst_req_o.ar.size  = size_t'($clog2(LiteBytes));
        mst_req_o.ar.burst = BURST_FIXED;
        mst_req_o.ar_valid = slv_req_lite_i.ar_valid & ~roff_full;
        mst_req_o.r_ready  = slv_req_lite_i.r_ready & ~roff_empty;
    end

    // Upstream response: B passes straight through, R is taken from the recorded lane.
    always_comb begin
        slv_resp_lite_o          = '0;
        slv_resp_lite_o.aw_ready = aw_gate & mst_resp_i.aw_ready;
        slv_resp_lite_o.w_ready  = ~woff_empty & mst_resp_i.w_ready;
        slv_resp_lite_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_lite_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_lite_o.ar_ready = ~roff_full & mst_resp_i.ar_ready;
        slv_resp_lite_o.r.data   = r_lanes[r_off];
        slv_resp_lite_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_lite_o.r_valid  = mst_resp_i.r_valid & ~roff_empty;
    end

    // IDs, user bits and last are fixed by construction and are not inspected.
    logic unused;
    assign unused = ^{mst_resp_i.b.id, mst_resp_i.b.user, mst_resp_i.r.id,
                      mst_resp_i.r.last, mst_resp_i.r.user};

endmodule
